// File: rtl/branch_predict_unit.sv
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Direct-mapped BTB with 2-bit counters for next-PC prediction in
//             IF; EX-stage resolution with mispredict/redirect and statistics.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic             isj_q    [ENTRIES];

    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] mispred_q,  mispred_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             resolve, taken;
    logic [XLEN-1:0]  seq_pc;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not seen.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && (isj_q[if_idx] || ctr_q[if_idx][1]);
    assign pred_target = pred_taken ? target_q[if_idx] : '0;

    // Resolution is suppressed while reset is held so outputs read zero.
    assign resolve = ex_valid && (ex_is_branch || ex_is_jump) && !reset;
    assign taken   = ex_is_jump || ex_taken;
    assign seq_pc  = ex_pc + XLEN'(4);
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (resolve && ((taken != ex_pred_taken) ||
                        (taken && (ex_target != ex_pred_target)))) begin
            mispredict  = 1'b1;
            redirect_pc = taken ? ex_target : seq_pc;
        end
    end

    always_comb begin
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (resolve)    branches_d = branches_q + CNT_W'(1);
        if (mispredict) mispred_d  = mispred_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                isj_q[i]    <= 1'b0;
            end
        end else if (resolve) begin
            if (ex_hit) begin
                if (taken) begin
                    target_q[ex_idx] <= ex_target;
                    if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end else if (taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= 2'b10;
                isj_q[ex_idx]    <= ex_is_jump;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;

endmodule

`default_nettype wire
